btn_event_ctrl: RTL and testbench

BTN_EVENT_CTRL -- requirements
Module: btn_event_ctrl

---
 rtl/btn_event_if.sv | 28 ++
 rtl/btn_event_ctrl.sv | 178 +++++++++++++++++
 tb/tb_btn_event_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/btn_event_if.sv
`default_nettype none
// ============================================================================
// Module   : btn_event_if
// Purpose  : Button inputs, timebase tick and event outputs of btn_event_ctrl.
// Revision : 1.0  initial release
// ============================================================================
interface btn_event_if;
    logic tick_1ms;
    logic btn_inc;
    logic btn_set;
    logic btn_sw;
    logic inc_short;
    logic inc_long;
    logic set;
    logic sw;
    logic busy;

    modport master (
        output tick_1ms, btn_inc, btn_set, btn_sw,
        input  inc_short, inc_long, set, sw, busy
    );

    modport slave (
        input  tick_1ms, btn_inc, btn_set, btn_sw,
        output inc_short, inc_long, set, sw, busy
    );
endinterface
`default_nettype wire

// File: rtl/btn_event_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : btn_event_ctrl
// Purpose  : Debounces three buttons, classifies inc presses (short/long) and
//            emits one-clk event pulses through a fixed-priority arbiter.
//            Optional auto-repeat while inc is long-held: BTN_AUTOREPEAT_EN.
// Revision : 1.0  initial release
// ============================================================================
module btn_event_ctrl #(
    parameter int DEB_MS    = 20,
    parameter int LONG_MS   = 1000,
    parameter int REPEAT_MS = 200
) (
    input  logic         clk,
    input  logic         rst_n,
    btn_event_if.slave   bus
);

    localparam logic [7:0]  c_deb_last  = 8'(DEB_MS - 1);
    localparam logic [11:0] c_long_last = 12'(LONG_MS - 1);

    if (DEB_MS < 1 || DEB_MS > 255 || LONG_MS <= DEB_MS || LONG_MS > 4095 ||
        REPEAT_MS < 1 || REPEAT_MS > 4095) begin : g_bad_params
        $error("btn_event_ctrl: parameter out of range");
    end

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_PRESSED   = 2'd1,
        S_LONG_HELD = 2'd2
    } state_t;

    // button index: 0 = inc, 1 = set, 2 = sw
    logic [2:0]  w_btn_raw;
    logic [2:0]  r_sync1;
    logic [2:0]  r_sync2;
    logic [2:0]  r_stable;
    logic [7:0]  r_deb_cnt [3];
    logic [2:0]  w_toggle;
    logic [2:0]  w_rise;
    logic        w_inc_fall;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [11:0] r_hold;
    logic        w_ev_short;
    logic        w_ev_long;

    // pending / output bit order doubles as priority: short, set, long, sw
    logic [3:0]  w_new;
    logic [3:0]  w_grant;
    logic [3:0]  r_pend;
    logic [3:0]  r_out;

    assign w_btn_raw = {bus.btn_sw, bus.btn_set, bus.btn_inc};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_btn_raw;
            r_sync2 <= r_sync1;
        end
    end

    always_comb begin
        w_toggle = '0;
        for (int i = 0; i < 3; i++) begin
            w_toggle[i] = (r_sync2[i] != r_stable[i]) && bus.tick_1ms &&
                          (r_deb_cnt[i] == c_deb_last);
        end
    end

    assign w_rise     = w_toggle & ~r_stable;
    assign w_inc_fall = w_toggle[0] & r_stable[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stable <= '0;
            for (int i = 0; i < 3; i++) r_deb_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (r_sync2[i] == r_stable[i]) begin
                    r_deb_cnt[i] <= '0;
                end else if (w_toggle[i]) begin
                    r_deb_cnt[i] <= '0;
                    r_stable[i]  <= ~r_stable[i];
                end else if (bus.tick_1ms) begin
                    r_deb_cnt[i] <= r_deb_cnt[i] + 8'd1;
                end
            end
        end
    end

`ifdef BTN_AUTOREPEAT_EN
    localparam logic [11:0] c_rep_last = 12'(REPEAT_MS - 1);
    logic [11:0] r_rep;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rep <= '0;
        end else if (r_state != S_LONG_HELD) begin
            r_rep <= '0;
        end else if (bus.tick_1ms) begin
            r_rep <= (r_rep == c_rep_last) ? 12'd0 : r_rep + 12'd1;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // a release on the very tick the hold would turn long still counts as short
    always_comb begin
        w_state_nxt = r_state;
        w_ev_short  = 1'b0;
        w_ev_long   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_rise[0]) w_state_nxt = S_PRESSED;
            end
            S_PRESSED: begin
                if (w_inc_fall) begin
                    w_ev_short  = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (bus.tick_1ms && r_hold == c_long_last) begin
                    w_ev_long   = 1'b1;
                    w_state_nxt = S_LONG_HELD;
                end
            end
            S_LONG_HELD: begin
                if (w_inc_fall) begin
                    w_state_nxt = S_IDLE;
                end
`ifdef BTN_AUTOREPEAT_EN
                else if (bus.tick_1ms && r_rep == c_rep_last) begin
                    w_ev_short = 1'b1;
                end
`endif
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold <= '0;
        end else if (r_state == S_IDLE) begin
            r_hold <= '0;
        end else if (bus.tick_1ms && r_hold != 12'hFFF) begin
            r_hold <= r_hold + 12'd1;
        end
    end

    assign w_new   = {w_rise[2], w_ev_long, w_rise[1], w_ev_short};
    assign w_grant = r_pend & (~r_pend + 4'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend <= '0;
            r_out  <= '0;
        end else begin
            r_pend <= (r_pend & ~w_grant) | w_new;
            r_out  <= w_grant;
        end
    end

    assign bus.inc_short = r_out[0];
    assign bus.set       = r_out[1];
    assign bus.inc_long  = r_out[2];
    assign bus.sw        = r_out[3];
    assign bus.busy      = |r_pend;

endmodule
`default_nettype wire

// File: tb/tb_btn_event_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_btn_event_ctrl
// Purpose  : Randomized scoreboard bench for btn_event_ctrl against a
//            timestamp-based behavioural model.
// Revision : 1.0  initial release
// ============================================================================
module tb_btn_event_ctrl;

    localparam int DEB  = 20;
    localparam int LONG = 1000;
    localparam int REP  = 200;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    btn_event_if bus ();

    btn_event_ctrl #(
        .DEB_MS    (DEB),
        .LONG_MS   (LONG),
        .REPEAT_MS (REP)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int cyc;
        int kind;   // 0 inc_short, 1 set, 2 inc_long, 3 sw
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   pulses[4];
    int   last_short_cyc = 0;
    int   last_set_cyc   = 0;
    int   busy_hi        = 0;

    // ---------------- reference model ----------------
    int       cyc = 0;
    int       g_ticks;
    int       mark[3];
    bit       s1[3], s2[3], stab[3];
    bit       m_rise[3], m_fall[3];
    bit       m_w, m_tk;
    bit [2:0] m_raw;
    bit       m_held, m_long;
    int       press_t, long_t;
    bit [3:0] m_ev;
    bit [3:0] m_pend;
    int       m_emit;

    // stable level flips once DEB ticks have elapsed since the input last agreed
    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            g_ticks = 0;
            for (int b = 0; b < 3; b++) begin
                mark[b] = 0; s1[b] = 0; s2[b] = 0; stab[b] = 0;
            end
            m_held = 0; m_long = 0; m_pend = '0;
        end else begin
            m_raw = {bus.btn_sw, bus.btn_set, bus.btn_inc};
            m_tk  = bus.tick_1ms;
            if (m_tk) g_ticks++;
            for (int b = 0; b < 3; b++) begin
                m_w = s2[b]; s2[b] = s1[b]; s1[b] = m_raw[b];
                m_rise[b] = 0; m_fall[b] = 0;
                if (m_w == stab[b]) mark[b] = g_ticks;
                else if (m_tk && (g_ticks - mark[b]) == DEB) begin
                    stab[b] = ~stab[b]; mark[b] = g_ticks;
                    m_rise[b] = stab[b]; m_fall[b] = !stab[b];
                end
            end
            m_ev = '0;
            if (m_rise[0]) begin
                m_held = 1; m_long = 0; press_t = g_ticks;
            end else if (m_held) begin
                if (m_fall[0]) begin
                    if (!m_long) m_ev[0] = 1;
                    m_held = 0;
                end else if (m_tk && !m_long && (g_ticks - press_t) == LONG) begin
                    m_ev[2] = 1; m_long = 1; long_t = g_ticks;
                end
`ifdef BTN_AUTOREPEAT_EN
                else if (m_tk && m_long && ((g_ticks - long_t) % REP) == 0) begin
                    m_ev[0] = 1;
                end
`endif
            end
            m_ev[1] = m_rise[1];
            m_ev[3] = m_rise[2];
            m_emit = -1;
            for (int k = 3; k >= 0; k--) if (m_pend[k]) m_emit = k;
            if (m_emit >= 0) begin
                m_pend[m_emit] = 0;
                q.push_back(exp_t'{cyc, m_emit});
            end
            m_pend = m_pend | m_ev;
        end
    end

    // ---------------- monitor ----------------
    logic [3:0] outs;
    int         kind;
    exp_t       e;

    always @(posedge clk) begin
        #1;
        outs = {bus.sw, bus.inc_long, bus.set, bus.inc_short};
        while (q.size() > 0 && q[0].cyc < cyc) begin
            n_checks++; n_errors++;
            $display("FAIL missed_pulse: kind %0d due at cycle %0d, got none (now %0d)",
                     q[0].kind, q[0].cyc, cyc);
            q.delete(0);
        end
        n_checks++;
        if ($countones(outs) > 1) begin
            n_errors++;
            $display("FAIL onehot: outputs %b at cycle %0d, required at most one high", outs, cyc);
        end else if (outs != 4'b0) begin
            kind = 0;
            for (int k = 0; k < 4; k++) if (outs[k]) kind = k;
            pulses[kind]++;
            if (kind == 0) last_short_cyc = cyc;
            if (kind == 1) last_set_cyc   = cyc;
            n_checks++;
            if (q.size() == 0) begin
                n_errors++;
                $display("FAIL unexpected_pulse: kind %0d at cycle %0d, required none", kind, cyc);
            end else begin
                e = q.pop_front();
                if (e.cyc != cyc || e.kind != kind) begin
                    n_errors++;
                    $display("FAIL pulse_match: got kind %0d at cycle %0d, required kind %0d at cycle %0d",
                             kind, cyc, e.kind, e.cyc);
                end
            end
        end
        n_checks++;
        if (bus.busy !== (m_pend != 4'b0)) begin
            n_errors++;
            $display("FAIL busy: got %b at cycle %0d, required %b", bus.busy, cyc, (m_pend != 4'b0));
        end
        if (bus.busy === 1'b1) busy_hi++;
    end

    // ---------------- stimulus ----------------
    initial begin
        bus.tick_1ms = 1'b0;
        forever begin
            @(negedge clk);
            bus.tick_1ms = ~bus.tick_1ms;
        end
    end

    task automatic wait_ticks(input int n);
        repeat (2 * n) @(negedge clk);
    endtask

    task automatic set_btn(input int b, input logic v);
        case (b)
            0:       bus.btn_inc = v;
            1:       bus.btn_set = v;
            default: bus.btn_sw  = v;
        endcase
    endtask

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic clear_counts();
        for (int k = 0; k < 4; k++) pulses[k] = 0;
    endtask

    int hi[3];
    int mask, hold;
    int exp_cnt[4];

    initial begin
        bus.btn_inc = 1'b0;
        bus.btn_set = 1'b0;
        bus.btn_sw  = 1'b0;
        clear_counts();
        repeat (4) @(negedge clk);
        chk("reset_outputs", {28'd0, outs}, 0);
        chk("reset_busy", int'(bus.busy), 0);
        rst_n = 1'b1;
        wait_ticks(30);

        // bouncy set press
        clear_counts();
        repeat (5) begin
            bus.btn_set = ~bus.btn_set;
            wait_ticks(1);
        end
        bus.btn_set = 1'b1;
        wait_ticks(30);
        bus.btn_set = 1'b0;
        wait_ticks(30);
        chk("bounce_set_once", pulses[1], 1);
        chk("bounce_set_others", pulses[0] + pulses[2] + pulses[3], 0);

        // short inc hold
        clear_counts();
        bus.btn_inc = 1'b1; wait_ticks(300);
        bus.btn_inc = 1'b0; wait_ticks(40);
        chk("hold300_short", pulses[0], 1);
        chk("hold300_long", pulses[2], 0);

        // long inc hold
        clear_counts();
        bus.btn_inc = 1'b1; wait_ticks(1500);
        bus.btn_inc = 1'b0; wait_ticks(40);
        chk("hold1500_long", pulses[2], 1);
`ifdef BTN_AUTOREPEAT_EN
        chk("hold1500_repeat", pulses[0], 2);
`else
        chk("hold1500_short", pulses[0], 0);
`endif

        // inc release and set press qualifying on the same clk
        clear_counts();
        bus.btn_inc = 1'b1; wait_ticks(40);
        bus.btn_inc = 1'b0;
        bus.btn_set = 1'b1; wait_ticks(40);
        chk("sameclk_short", pulses[0], 1);
        chk("sameclk_set", pulses[1], 1);
        chk("sameclk_order", last_set_cyc - last_short_cyc, 1);
        bus.btn_set = 1'b0; wait_ticks(40);

        // reset while inc is held mid-press
        bus.btn_inc = 1'b1; wait_ticks(520);
        rst_n = 1'b0;
        #1;
        chk("midreset_outputs", int'({bus.sw, bus.inc_long, bus.set, bus.inc_short}), 0);
        chk("midreset_busy", int'(bus.busy), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        clear_counts();
        wait_ticks(18);
        chk("requal_quiet", pulses[0] + pulses[1] + pulses[2] + pulses[3], 0);
        wait_ticks(100);
        bus.btn_inc = 1'b0; wait_ticks(40);
        chk("requal_short", pulses[0], 1);
        chk("requal_long", pulses[2], 0);

        // random clean presses, possibly several buttons at once
        clear_counts();
        for (int k = 0; k < 4; k++) exp_cnt[k] = 0;
        for (int it = 0; it < 30; it++) begin
            mask = $urandom_range(1, 7);
            hold = $urandom_range(25, 80);
            for (int b = 0; b < 3; b++) if (mask[b]) set_btn(b, 1'b1);
            wait_ticks(hold);
            for (int b = 0; b < 3; b++) set_btn(b, 1'b0);
            wait_ticks($urandom_range(25, 40));
            exp_cnt[0] += mask[0]; exp_cnt[1] += mask[1]; exp_cnt[3] += mask[2];
        end
        chk("rand_short", pulses[0], exp_cnt[0]);
        chk("rand_set", pulses[1], exp_cnt[1]);
        chk("rand_sw", pulses[3], exp_cnt[3]);
        chk("rand_long", pulses[2], 0);

        // sub-threshold bounce on every button
        clear_counts();
        busy_hi = 0;
        for (int b = 0; b < 3; b++) hi[b] = 0;
        for (int t = 0; t < 10000; t++) begin
            for (int b = 0; b < 3; b++) begin
                if (hi[b] > 0) begin
                    hi[b]--;
                    if (hi[b] == 0) set_btn(b, 1'b0);
                end else if ($urandom_range(0, 3) == 0) begin
                    set_btn(b, 1'b1);
                    hi[b] = $urandom_range(1, DEB - 4);
                end
            end
            wait_ticks(1);
        end
        for (int b = 0; b < 3; b++) set_btn(b, 1'b0);
        wait_ticks(30);
        chk("bounce_no_pulses", pulses[0] + pulses[1] + pulses[2] + pulses[3], 0);
        chk("bounce_busy_never", busy_hi, 0);

        wait_ticks(10);
        chk("scoreboard_drained", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
